// File: rtl/conv_sched_pkg.sv
// Shared types and sizes for the conv_sched convolution scheduler.
package conv_sched_pkg;

  localparam int DATA_W    = 8;
  localparam int FEED_CYC  = 5;
  localparam int IMG_N     = 4;
  localparam int KER_N     = 3;
  localparam int A_BITS    = IMG_N * IMG_N * DATA_W;
  localparam int B_BITS    = KER_N * KER_N * DATA_W;
  localparam int LANE_BITS = KER_N * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/conv_sched_skew.sv
// Combinational skewed lane selection: lane i carries A[r+i][c+k] and B[i][k] with k = t - i,
// or zero while k is outside 0..2. Lane i occupies bits [8i+7:8i] of din_o/win_o.
module conv_sched_skew
  import conv_sched_pkg::*;
(
  input  logic [2:0]           t_i,
  input  logic                 r_i,
  input  logic                 c_i,
  input  logic [A_BITS-1:0]    a_i,
  input  logic [B_BITS-1:0]    b_i,
  output logic [LANE_BITS-1:0] din_o,
  output logic [LANE_BITS-1:0] win_o
);

  logic [DATA_W-1:0] a_px [IMG_N*IMG_N];
  logic [DATA_W-1:0] b_px [KER_N*KER_N];

  for (genvar g = 0; g < IMG_N*IMG_N; g++) begin : g_a
    assign a_px[g] = a_i[DATA_W*g +: DATA_W];
  end
  for (genvar g = 0; g < KER_N*KER_N; g++) begin : g_b
    assign b_px[g] = b_i[DATA_W*g +: DATA_W];
  end

  logic [2:0] lane;
  logic [2:0] kk;
  logic [1:0] row;
  logic [1:0] col;
  logic [3:0] bidx;

  always_comb begin
    din_o = '0;
    win_o = '0;
    lane  = '0;
    kk    = '0;
    row   = '0;
    col   = '0;
    bidx  = '0;
    for (int i = 0; i < KER_N; i++) begin
      lane = 3'(i);
      kk   = t_i - lane;
      row  = {1'b0, r_i} + lane[1:0];
      col  = {1'b0, c_i} + kk[1:0];
      bidx = 4'(KER_N * i) + {2'b00, kk[1:0]};
      // t_i >= lane rules out the wrapped (negative) k values
      if (t_i >= lane && kk <= 3'd2) begin
        din_o[DATA_W*i +: DATA_W] = a_px[{row, col}];
        win_o[DATA_W*i +: DATA_W] = b_px[bidx];
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Sequences a 3x3 systolic array over the four 2x2 output pixels of a latched 4x4 image / 3x3 kernel.
// Every output is registered one cycle behind the FSM state; CONV_SCHED_PERF_CNT_EN adds run_cycles.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int DRAIN_CYC = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [A_BITS-1:0]   a_flat,
  input  logic [B_BITS-1:0]   b_flat,
  output logic [DATA_W-1:0]   din0,
  output logic [DATA_W-1:0]   din1,
  output logic [DATA_W-1:0]   din2,
  output logic [DATA_W-1:0]   win0,
  output logic [DATA_W-1:0]   win1,
  output logic [DATA_W-1:0]   win2,
  output logic                clear,
  output logic                c00,
  output logic                c01,
  output logic                c10,
  output logic                c11,
  output logic                busy,
  output logic                done
`ifdef CONV_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]         run_cycles
`endif
);

  localparam logic [3:0] FEED_LAST  = 4'(FEED_CYC - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [1:0]          p_q;
  logic [A_BITS-1:0]   a_q;
  logic [B_BITS-1:0]   b_q;
  logic [LANE_BITS-1:0] din_q, win_q;
  logic [LANE_BITS-1:0] din_d, win_d;
  logic [3:0]          cap_q;
  logic                clear_q, busy_q, done_q;

  conv_sched_skew u_skew (
    .t_i   (cnt_q[2:0]),
    .r_i   (p_q[1]),
    .c_i   (p_q[0]),
    .a_i   (a_q),
    .b_i   (b_q),
    .din_o (din_d),
    .win_o (win_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      din_q   <= '0;
      win_q   <= '0;
      cap_q   <= '0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q  <= (state_q != ST_IDLE);
      clear_q <= (state_q == ST_CLEAR);
      done_q  <= (state_q == ST_DONE);
      cap_q   <= (state_q == ST_CAPTURE) ? (4'b0001 << p_q) : 4'b0000;
      din_q   <= (state_q == ST_FEED) ? din_d : '0;
      win_q   <= (state_q == ST_FEED) ? win_d : '0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a_flat;
            b_q     <= b_flat;
            p_q     <= '0;
            cnt_q   <= '0;
            state_q <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          cnt_q   <= '0;
          state_q <= ST_FEED;
        end
        ST_FEED: begin
          if (cnt_q == FEED_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_CAPTURE: begin
          if (p_q == 2'd3) begin
            state_q <= ST_DONE;
          end else begin
            p_q     <= p_q + 2'd1;
            state_q <= ST_CLEAR;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign din0  = din_q[0*DATA_W +: DATA_W];
  assign din1  = din_q[1*DATA_W +: DATA_W];
  assign din2  = din_q[2*DATA_W +: DATA_W];
  assign win0  = win_q[0*DATA_W +: DATA_W];
  assign win1  = win_q[1*DATA_W +: DATA_W];
  assign win2  = win_q[2*DATA_W +: DATA_W];
  assign clear = clear_q;
  assign c00   = cap_q[0];
  assign c01   = cap_q[1];
  assign c10   = cap_q[2];
  assign c11   = cap_q[3];
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef CONV_SCHED_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d, run_q;

  assign cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

  // cyc_d on the DONE state cycle equals the number of busy output cycles of the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      run_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      if (state_q == ST_DONE) run_q <= cyc_d;
    end
  end

  assign run_cycles = run_q;
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: default instance plus a DRAIN_CYC=1 instance.
module tb_conv_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1;
  logic [127:0] a_flat, a_save;
  logic [71:0]  b_flat, b_save;
  wire  [47:0]  lane0, lane1;
  wire  [5:0]   stb0, stb1;
  wire          busy0, busy1;
  int           n_vec = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

`ifdef CONV_SCHED_PERF_CNT_EN
  wire [15:0] rc0, rc1;
`endif

  conv_sched u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_flat(a_flat), .b_flat(b_flat),
    .din0(lane0[47:40]), .din1(lane0[39:32]), .din2(lane0[31:24]),
    .win0(lane0[23:16]), .win1(lane0[15:8]), .win2(lane0[7:0]),
    .clear(stb0[5]), .c00(stb0[4]), .c01(stb0[3]), .c10(stb0[2]), .c11(stb0[1]),
    .busy(busy0), .done(stb0[0])
`ifdef CONV_SCHED_PERF_CNT_EN
    , .run_cycles(rc0)
`endif
  );

  conv_sched #(.DRAIN_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_flat(a_flat), .b_flat(b_flat),
    .din0(lane1[47:40]), .din1(lane1[39:32]), .din2(lane1[31:24]),
    .win0(lane1[23:16]), .win1(lane1[15:8]), .win2(lane1[7:0]),
    .clear(stb1[5]), .c00(stb1[4]), .c01(stb1[3]), .c10(stb1[2]), .c11(stb1[1]),
    .busy(busy1), .done(stb1[0])
`ifdef CONV_SCHED_PERF_CNT_EN
    , .run_cycles(rc1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {clear, c00, c01, c10, c11, done} for cycle n after the start edge
  function automatic logic [5:0] exp_stb(input int n, input int per);
    int s;
    exp_stb = '0;
    if (n >= 1 && n <= 4*per) begin
      s = (n-1) % per;
      if (s == 0) exp_stb[5] = 1'b1;
      else if (s == per-1) exp_stb[4 - (n-1)/per] = 1'b1;
    end else if (n == 4*per+1) begin
      exp_stb[0] = 1'b1;
    end
  endfunction

  // {din0, din1, din2, win0, win1, win2} from the operands saved at start
  function automatic logic [47:0] exp_lanes(input int n, input int per);
    int s, p, t, k, r, c;
    exp_lanes = '0;
    if (n >= 1 && n <= 4*per) begin
      p = (n-1) / per;
      s = (n-1) % per;
      if (s >= 1 && s <= 5) begin
        t = s - 1;
        r = p / 2;
        c = p % 2;
        for (int i = 0; i < 3; i++) begin
          k = t - i;
          if (k >= 0 && k <= 2) begin
            exp_lanes[47-8*i -: 8] = a_save[8*(4*(r+i)+c+k) +: 8];
            exp_lanes[23-8*i -: 8] = b_save[8*(3*i+k) +: 8];
          end
        end
      end
    end
  endfunction

  task automatic check_dut(input string nm, input int n, input int per, input bit live,
                           input int cut, input logic [5:0] stb, input logic bsy,
                           input logic [47:0] ln);
    logic [5:0]  es;
    logic        eb;
    logic [47:0] el;
    es = '0;
    eb = 1'b0;
    el = '0;
    if (live && n <= cut) begin
      es = exp_stb(n, per);
      eb = (n >= 1 && n <= 4*per+1);
      el = exp_lanes(n, per);
    end
    chk($sformatf("%s_strobes@%0d", nm, n), 64'(stb), 64'(es));
    chk($sformatf("%s_busy@%0d", nm, n), 64'(bsy), 64'(eb));
    chk($sformatf("%s_lanes@%0d", nm, n), 64'(ln), 64'(el));
  endtask

  task automatic kick(input bit both);
    a_save = a_flat;
    b_save = b_flat;
    start0 = 1'b1;
    start1 = both;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // mode 1: all-ones run with mid-run start pulses and operand change
  // mode 2: hand-computed lane vectors; mode 3: reset at rst_at
  task automatic scan(input int n_last, input bit live1, input int rst_at, input int mode);
    int ones [4];
    int cut;
    for (int p = 0; p < 4; p++) ones[p] = 0;
    cut = (mode == 3) ? rst_at : 1000;
    for (int n = 1; n <= n_last; n++) begin
      @(posedge clk);
      #1;
      check_dut("u0", n, 10, 1'b1, cut, stb0, busy0, lane0);
      check_dut("u1", n, 8, live1, 1000, stb1, busy1, lane1);
      if (mode == 1) begin
        if (n <= 40) begin
          for (int i = 0; i < 3; i++)
            if (lane0[47-8*i -: 8] == 8'd1 && lane0[23-8*i -: 8] == 8'd1) ones[(n-1)/10]++;
        end
        if (n == 2 || n == 40) start0 = 1'b1;
        if (n == 3 || n == 41) start0 = 1'b0;
        if (n == 5) a_flat = '1;
      end
      if (mode == 2) begin
        if (n == 2)  chk("pat_p0_t0", 64'(lane0), 64'h0000_0000_0100_00);
        if (n == 16) chk("pat_p1_t4", 64'(lane0), 64'h0000_0000_0B00_0009);
        if (n == 34) chk("pat_p3_t2", 64'(lane0), 64'h0000_070A_0D03_0507);
      end
      if (mode == 3) begin
        if (n == rst_at) begin
          rst = 1'b1;
          #1;
          chk("rst_async_strobes", 64'(stb0), 64'd0);
          chk("rst_async_busy", 64'(busy0), 64'd0);
          chk("rst_async_lanes", 64'(lane0), 64'd0);
        end
        if (n == rst_at + 2) rst = 1'b0;
      end
    end
    if (mode == 1) begin
      for (int p = 0; p < 4; p++) chk($sformatf("ones_lanes_p%0d", p), 64'(ones[p]), 64'd9);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    a_flat = '0;
    b_flat = '0;
    a_save = '0;
    b_save = '0;
    #2;
    chk("reset_strobes0", 64'(stb0), 64'd0);
    chk("reset_busy0", 64'(busy0), 64'd0);
    chk("reset_lanes0", 64'(lane0), 64'd0);
    chk("reset_strobes1", 64'(stb1), 64'd0);
`ifdef CONV_SCHED_PERF_CNT_EN
    chk("reset_run_cycles", 64'(rc0), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy0", 64'(busy0), 64'd0);

    a_flat = {16{8'h01}};
    b_flat = {9{8'h01}};
    kick(1'b1);
    scan(46, 1'b1, 0, 1);
`ifdef CONV_SCHED_PERF_CNT_EN
    chk("run_cycles_d3", 64'(rc0), 64'd41);
    chk("run_cycles_d1", 64'(rc1), 64'd33);
`endif

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) a_flat[8*(4*r+c) +: 8] = 8'(4*r + c);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) b_flat[8*(3*i+k) +: 8] = 8'(3*i + k + 1);
    kick(1'b0);
    scan(44, 1'b0, 0, 2);

    kick(1'b0);
    scan(45, 1'b0, 25, 3);
`ifdef CONV_SCHED_PERF_CNT_EN
    chk("run_cycles_after_rst", 64'(rc0), 64'd0);
`endif

    kick(1'b0);
    scan(44, 1'b0, 0, 0);
`ifdef CONV_SCHED_PERF_CNT_EN
    chk("run_cycles_fresh", 64'(rc0), 64'd41);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
